// File: rtl/hyper_ddr_tx.sv
// Transmit-side DDR datapath for the HyperBus controller: TX word FIFO, latency wait,
// then one registered rising/falling half pair plus RWDS mask per clock.
module hyper_ddr_tx #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned LAT_W      = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  burst_len_i,
    input  logic [LAT_W-1:0]  latency_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [1:0]        in_strb_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] ddr_data_o,
    output logic [1:0]        ddr_rwds_o,
    output logic              ddr_oe_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              underrun_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, WAIT, DATA, DONE} state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LAT_W-1:0]  lat_q, lat_d;

    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [1:0]        mem_strb_q [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
    logic              full, empty, push, pop, beat;

    logic [DATA_W-1:0] ddr_data_q, ddr_data_d;
    logic [1:0]        ddr_rwds_q, ddr_rwds_d;
    logic              ddr_oe_q, ddr_oe_d;
    logic              underrun_q, underrun_d;

    // RWDS is a write mask: high means the half is not written.
    function automatic logic [1:0] rwds_mask(input logic [1:0] strb);
        return ~strb;
    endfunction

    // Extra pointer MSB distinguishes full from empty.
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign in_ready_o = !full;
    assign push       = in_valid_i && !full;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data_q[wr_ptr_q[PTR_W-1:0]] <= in_data_i;
            mem_strb_q[wr_ptr_q[PTR_W-1:0]] <= in_strb_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        lat_d   = lat_q;
        pop     = 1'b0;
        beat    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rem_d = burst_len_i;
                    lat_d = latency_i;
                    if (burst_len_i == '0)     state_d = DONE;
                    else if (latency_i == '0)  state_d = DATA;
                    else                       state_d = WAIT;
                end
            end
            WAIT: begin
                lat_d = lat_q - LAT_ONE;
                if (lat_q == LAT_ONE) state_d = DATA;
            end
            DATA: begin
                // Beats never stall: an empty FIFO produces a masked filler beat.
                beat  = 1'b1;
                pop   = !empty;
                rem_d = rem_q - LEN_ONE;
                if (rem_q == LEN_ONE) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ddr_data_d = '0;
        ddr_rwds_d = 2'b00;
        ddr_oe_d   = 1'b0;
        underrun_d = underrun_q;
        if (beat) begin
            ddr_oe_d = 1'b1;
            if (pop) begin
                ddr_data_d = mem_data_q[rd_ptr_q[PTR_W-1:0]];
                ddr_rwds_d = rwds_mask(mem_strb_q[rd_ptr_q[PTR_W-1:0]]);
            end else begin
                ddr_rwds_d = 2'b11;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            lat_q      <= '0;
            ddr_data_q <= '0;
            ddr_rwds_q <= 2'b00;
            ddr_oe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            lat_q      <= lat_d;
            ddr_data_q <= ddr_data_d;
            ddr_rwds_q <= ddr_rwds_d;
            ddr_oe_q   <= ddr_oe_d;
            underrun_q <= underrun_d;
        end
    end

    assign ddr_data_o = ddr_data_q;
    assign ddr_rwds_o = ddr_rwds_q;
    assign ddr_oe_o   = ddr_oe_q;
    assign underrun_o = underrun_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_hyper_ddr_tx.sv
// Bench for hyper_ddr_tx: table of burst vectors plus hand sequences for
// full-FIFO push/pop, held start, clear mid-burst and reset mid-wait.
module tb_hyper_ddr_tx;

    logic        clk = 1'b0;
    logic        rst_ni, clear_i, start_i, in_valid_i;
    logic [15:0] burst_len_i;
    logic [4:0]  latency_i;
    logic [15:0] in_data_i;
    logic [1:0]  in_strb_i;
    logic        in_ready_o, ddr_oe_o, busy_o, done_o, underrun_o;
    logic [15:0] ddr_data_o;
    logic [1:0]  ddr_rwds_o;

    int total = 0;
    int bad   = 0;

    logic [17:0] mq[$];   // words the DUT FIFO should hold: {data, strb}
    logic [17:0] sb[$];   // expected beats: {data, rwds}

    typedef struct {
        int               npre;
        logic [3:0][15:0] w;
        logic [3:0][1:0]  s;
        int               len;
        int               lat;
        bit               und;
    } vec_t;

    vec_t vecs [7];

    hyper_ddr_tx #(.DATA_W(16), .FIFO_DEPTH(4), .LEN_W(16), .LAT_W(5)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .burst_len_i(burst_len_i), .latency_i(latency_i),
        .in_data_i(in_data_i), .in_strb_i(in_strb_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .ddr_data_o(ddr_data_o), .ddr_rwds_o(ddr_rwds_o),
        .ddr_oe_o(ddr_oe_o), .busy_o(busy_o), .done_o(done_o), .underrun_o(underrun_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        mq.delete();
        sb.delete();
    endtask

    task automatic push_word(input logic [15:0] d, input logic [1:0] s);
        int t = 0;
        @(negedge clk);
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_strb_i  = s;
        while (!in_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready_o) begin
            chk("push_timeout", 32'(in_ready_o), 32'd1);
        end else begin
            @(posedge clk);
            #1;
            mq.push_back({d, s});
        end
        in_valid_i = 1'b0;
    endtask

    // Drives start at a negedge; edge E0 samples it. Expected beats are queued
    // half a cycle before the edge that pops them and checked after it.
    task automatic run_burst(input int len, input int lat, input bit hold);
        int          last;
        bit          beat;
        logic [17:0] e;
        last = (len == 0) ? 1 : lat + len + 1;
        @(negedge clk);
        start_i     = 1'b1;
        burst_len_i = 16'(len);
        latency_i   = 5'(lat);
        for (int j = 0; j <= last; j++) begin
            beat = (len > 0) && (j >= lat + 1) && (j <= lat + len);
            if (beat) begin
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    sb.push_back({e[17:2], ~e[1:0]});
                end else begin
                    sb.push_back({16'h0000, 2'b11});
                end
            end
            @(negedge clk);
            if (!hold || done_o) start_i = 1'b0;
            chk("oe", 32'(ddr_oe_o), 32'(beat));
            if (ddr_oe_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 32'(ddr_oe_o), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", 32'(ddr_data_o), 32'(e[17:2]));
                    chk("beat_rwds", 32'(ddr_rwds_o), 32'(e[1:0]));
                end
            end else begin
                chk("idle_data", 32'(ddr_data_o), 32'd0);
                chk("idle_rwds", 32'(ddr_rwds_o), 32'd0);
            end
            chk("done", 32'(done_o), 32'((len == 0) ? (j == 0) : (j == lat + len)));
            chk("busy", 32'(busy_o), 32'((len == 0) ? (j == 0) : (j <= lat + len)));
        end
        start_i = 1'b0;
        chk("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_oe"},   32'(ddr_oe_o),   32'd0);
        chk({tag, "_data"}, 32'(ddr_data_o), 32'd0);
        chk({tag, "_rwds"}, 32'(ddr_rwds_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o),     32'd0);
        chk({tag, "_done"}, 32'(done_o),     32'd0);
        chk({tag, "_und"},  32'(underrun_o), 32'd0);
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0;
        burst_len_i = '0; latency_i = '0; in_data_i = '0; in_strb_i = '0;

        // npre, words {w3,w2,w1,w0}, strobes {s3,s2,s1,s0}, len, lat, underrun
        vecs[0] = '{2, {16'h0, 16'h0, 16'h3C3C, 16'hA5A5}, {2'b00, 2'b00, 2'b10, 2'b11}, 2, 0, 1'b0};
        vecs[1] = '{1, {16'h0, 16'h0, 16'h0, 16'h1234},    {2'b00, 2'b00, 2'b00, 2'b01}, 1, 3, 1'b0};
        vecs[2] = '{1, {16'h0, 16'h0, 16'h0, 16'hBEEF},    {2'b00, 2'b00, 2'b00, 2'b11}, 3, 0, 1'b1};
        vecs[3] = '{0, {16'h0, 16'h0, 16'h0, 16'h0},       {2'b00, 2'b00, 2'b00, 2'b00}, 0, 2, 1'b0};
        vecs[4] = '{4, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, {2'b00, 2'b01, 2'b10, 2'b11}, 4, 1, 1'b0};
        vecs[5] = '{3, {16'h0, 16'h7C7C, 16'h6B6B, 16'h5A5A}, {2'b00, 2'b10, 2'b01, 2'b11}, 2, 0, 1'b0};
        vecs[6] = '{0, {16'h0, 16'h0, 16'h0, 16'h0},       {2'b00, 2'b00, 2'b00, 2'b00}, 2, 1, 1'b1};

        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(in_ready_o), 32'd1);

        for (int v = 0; v < 7; v++) begin
            clear_pulse();
            for (int i = 0; i < vecs[v].npre; i++) push_word(vecs[v].w[i], vecs[v].s[i]);
            if (vecs[v].npre == 4) chk("full_ready", 32'(in_ready_o), 32'd0);
            run_burst(vecs[v].len, vecs[v].lat, 1'b0);
            chk("underrun", 32'(underrun_o), 32'(vecs[v].und));
        end

        // Full FIFO while a burst drains it: held pushes must land in order.
        clear_pulse();
        push_word(16'hA001, 2'b11);
        push_word(16'hA002, 2'b10);
        push_word(16'hA003, 2'b01);
        push_word(16'hA004, 2'b11);
        chk("full_ready2", 32'(in_ready_o), 32'd0);
        fork
            run_burst(6, 0, 1'b0);
            begin
                push_word(16'hB005, 2'b10);
                push_word(16'hB006, 2'b01);
            end
        join
        chk("full_und", 32'(underrun_o), 32'd0);

        // start_i held through the burst: exactly one burst.
        clear_pulse();
        push_word(16'hC0DE, 2'b11);
        run_burst(1, 2, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("hold_busy", 32'(busy_o), 32'd0);
            chk("hold_oe",   32'(ddr_oe_o), 32'd0);
        end

        // clear_i mid-DATA flushes state, outputs and FIFO.
        clear_pulse();
        push_word(16'hD001, 2'b11);
        push_word(16'hD002, 2'b11);
        push_word(16'hD003, 2'b11);
        push_word(16'hD004, 2'b11);
        @(negedge clk);
        start_i = 1'b1; burst_len_i = 16'd4; latency_i = 5'd0;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("clr_beat1_oe",   32'(ddr_oe_o),   32'd1);
        chk("clr_beat1_data", 32'(ddr_data_o), 32'hD001);
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        mq.delete();
        chk_reset_outputs("clr");
        chk("clr_ready", 32'(in_ready_o), 32'd1);
        run_burst(1, 0, 1'b0);
        chk("clr_flush_und", 32'(underrun_o), 32'd1);

        // Reset mid-WAIT after a sticky underrun.
        clear_pulse();
        run_burst(1, 0, 1'b0);
        @(negedge clk);
        chk("sticky_und", 32'(underrun_o), 32'd1);
        push_word(16'hE00E, 2'b11);
        @(negedge clk);
        start_i = 1'b1; burst_len_i = 16'd2; latency_i = 5'd6;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("wait_busy", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rstw");
        rst_ni = 1'b1;
        mq.delete();
        @(negedge clk);
        chk("rstw_ready", 32'(in_ready_o), 32'd1);
        chk("rstw_busy2", 32'(busy_o),     32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
